// File: rtl/text_pkg.sv
// Shared widths and decoder state encoding for the SPI text loader.
package text_pkg;

   localparam int ADDR_W   = 15;
   localparam int SCROLL_W = 7;
   localparam int DATA_W   = 8;

   // Byte position within one SSEL-low transaction.
   typedef enum logic [1:0] {
      S_SCROLL = 2'd0,
      S_HI     = 2'd1,
      S_LO     = 2'd2,
      S_DATA   = 2'd3
   } state_t;

endpackage

// File: rtl/spi_text_loader_if.sv
// SPI pins plus the text-RAM write port and scroll value.
interface spi_text_loader_if;
   import text_pkg::*;

   logic                SCK;
   logic                MOSI;
   logic                SSEL;
   logic                MISO;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [DATA_W-1:0]   wdata;
   logic [SCROLL_W-1:0] scroll;

   // The loader side.
   modport slave (
      input  SCK, MOSI, SSEL,
      output MISO, we, waddr, wdata, scroll
   );

   // The SPI host / display side.
   modport master (
      output SCK, MOSI, SSEL,
      input  MISO, we, waddr, wdata, scroll
   );

endinterface

// File: rtl/spi_text_loader_sync_edge.sv
// Multi-flop synchronizer with one extra copy for edge detection.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   input  logic RESET_VAL,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the raw pin through the chain; prev_q lags the last stage by one clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_text_loader.sv
// Oversampled SPI slave that decodes scroll/address/data bytes into
// text-RAM writes, all in the pixel clock domain.
module spi_text_loader
   import text_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  XMIT        = 8'hA0
) (
   input logic                clk,
   input logic                rst,
   spi_text_loader_if.slave   bus
);

   logic                sck_rise, sck_fall, sck_lvl_unused;
   logic                ssel_lvl;
   logic [1:0]          ssel_edges_unused;
   logic                mosi_lvl;
   logic [1:0]          mosi_edges_unused;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
      .clk(clk), .rst(rst), .async_in(bus.SCK), .RESET_VAL(1'b0),
      .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));

   sync_edge #(.STAGES(SYNC_STAGES)) u_ssel (
      .clk(clk), .rst(rst), .async_in(bus.SSEL), .RESET_VAL(1'b1),
      .level(ssel_lvl), .rise(ssel_edges_unused[0]), .fall(ssel_edges_unused[1]));

   sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
      .clk(clk), .rst(rst), .async_in(bus.MOSI), .RESET_VAL(1'b0),
      .level(mosi_lvl), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1]));

   // The SSEL chain starts out forced high by reset, so a real deselect can
   // only be trusted once the chain and edge copy hold genuine samples.
   logic [SYNC_STAGES:0] vld_pipe;
   logic                 settled;

   // Fill with ones after reset; the top bit marks the sync chain as flushed.
   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
   end
   assign settled = vld_pipe[SYNC_STAGES];

   state_t              state;
   logic [2:0]          bitcnt;
   logic [7:0]          shift;
   logic [7:0]          rx_byte;
   logic                byte_stb;
   logic                need_desel;
   logic [ADDR_W-1:0]   addr;
   logic                miso_q, we_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [SCROLL_W-1:0] scroll_q;

   // Bit receiver, MISO shifter and byte decoder; deselect overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_SCROLL;
         bitcnt     <= '0;
         shift      <= '0;
         rx_byte    <= '0;
         byte_stb   <= 1'b0;
         need_desel <= 1'b1;
         addr       <= '0;
         miso_q     <= 1'b0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         scroll_q   <= '0;
      end else begin
         byte_stb <= 1'b0;
         we_q     <= 1'b0;
         if (need_desel) begin
            // Ignore a transaction cut by reset until SSEL is seen high.
            if (settled && ssel_lvl) need_desel <= 1'b0;
         end else if (ssel_lvl) begin
            bitcnt <= '0;
            shift  <= '0;
            state  <= S_SCROLL;
            miso_q <= XMIT[7];
         end else begin
            if (sck_rise) begin
               shift  <= {shift[6:0], mosi_lvl};
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  byte_stb <= 1'b1;
                  rx_byte  <= {shift[6:0], mosi_lvl};
               end
            end
            // bitcnt already counts the preceding rise, so this is the next bit out.
            if (sck_fall) miso_q <= XMIT[3'd7 - bitcnt];
            if (byte_stb) begin
               case (state)
                  S_SCROLL: begin
                     scroll_q <= rx_byte[SCROLL_W-1:0];
                     state    <= S_HI;
                  end
                  S_HI: begin
                     addr[ADDR_W-1:8] <= rx_byte[6:0];
                     state            <= S_LO;
                  end
                  S_LO: begin
                     addr[7:0] <= rx_byte;
                     state     <= S_DATA;
                  end
                  default: begin
                     we_q    <= 1'b1;
                     waddr_q <= addr;
                     wdata_q <= rx_byte;
                     addr    <= addr + 1'b1;
                  end
               endcase
            end
         end
      end
   end

   assign bus.MISO   = miso_q;
   assign bus.we     = we_q;
   assign bus.waddr  = waddr_q;
   assign bus.wdata  = wdata_q;
   assign bus.scroll = scroll_q;

endmodule

// File: tb/tb_spi_text_loader.sv
// Randomized bench for spi_text_loader against a transaction-level model.
module tb_spi_text_loader;
   import text_pkg::*;

   localparam int         HALF = 4;
   localparam logic [7:0] XMIT = 8'hA0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_text_loader_if bus();

   spi_text_loader #(.SYNC_STAGES(2), .XMIT(XMIT)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [22:0] got_q[$];
   logic [22:0] exp_q[$];
   logic [6:0]  exp_scroll;
   logic [22:0] last_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Collect every write strobe seen by the display side.
   always @(negedge clk) if (!rst && bus.we) got_q.push_back({bus.waddr, bus.wdata});

   task automatic clk_bit(input logic b, input logic do_chk, input logic exp_miso);
      bus.MOSI = b;
      repeat (HALF) @(negedge clk);
      if (do_chk) chk("miso", 32'(bus.MISO), 32'(exp_miso));
      bus.SCK = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCK = 1'b0;
   endtask

   // Model: byte0 = scroll, bytes1/2 = 15-bit start address, rest written sequentially.
   task automatic model(input logic [7:0] bq[$]);
      logic [14:0] a;
      if (bq.size() > 0) exp_scroll = bq[0][6:0];
      if (bq.size() > 3) begin
         a = {bq[1][6:0], bq[2]};
         for (int i = 3; i < bq.size(); i++) begin
            exp_q.push_back({a, bq[i]});
            last_exp = {a, bq[i]};
            a = a + 15'd1;
         end
      end
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         chk({tag, "_wr"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      got_q.delete();
      exp_q.delete();
      chk({tag, "_scroll"}, 32'(bus.scroll), 32'(exp_scroll));
      chk({tag, "_hold"}, 32'({bus.waddr, bus.wdata}), 32'(last_exp));
      chk({tag, "_we_idle"}, 32'(bus.we), 32'd0);
   endtask

   task automatic send_bytes(input logic [7:0] bq[$], input int partial);
      bus.SSEL = 1'b0;
      repeat (HALF) @(negedge clk);
      foreach (bq[i])
         for (int k = 0; k < 8; k++) clk_bit(bq[i][7-k], 1'b1, XMIT[7-k]);
      for (int k = 0; k < partial; k++) clk_bit(1'($urandom_range(0, 1)), 1'b1, XMIT[7-k]);
      repeat (8) @(negedge clk);
      bus.SSEL = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic txn(input logic [7:0] bq[$], input int partial, input string tag);
      send_bytes(bq, partial);
      model(bq);
      check_writes(tag);
   endtask

   initial begin
      logic [7:0] q[$];
      bus.SCK = 1'b0; bus.MOSI = 1'b0; bus.SSEL = 1'b1;
      exp_scroll = '0; last_exp = '0;
      repeat (4) @(negedge clk);
      chk("rst_we", 32'(bus.we), 32'd0);
      chk("rst_miso", 32'(bus.MISO), 32'd0);
      chk("rst_scroll", 32'(bus.scroll), 32'd0);
      chk("rst_wport", 32'({bus.waddr, bus.wdata}), 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("idle_miso", 32'(bus.MISO), 32'(XMIT[7]));

      q = '{8'h05};                             txn(q, 0, "scroll");
      q = '{8'h03, 8'h12, 8'h34, 8'h41, 8'h07}; txn(q, 0, "basic");
      q = '{8'h00, 8'hFF, 8'hFF, 8'hAA, 8'hBB}; txn(q, 0, "wrap");
      q = '{8'h02, 8'h00, 8'h20};               txn(q, 4, "abort_part");
      q = '{8'h01, 8'h00, 8'h10, 8'h99};        txn(q, 0, "abort_new");

      // 8th SCK rise and SSEL release arrive together: deselect must win.
      q = '{8'h04, 8'h00, 8'h40};
      bus.SSEL = 1'b0;
      repeat (HALF) @(negedge clk);
      foreach (q[i]) for (int k = 0; k < 8; k++) clk_bit(q[i][7-k], 1'b1, XMIT[7-k]);
      for (int k = 0; k < 7; k++) clk_bit(1'b1, 1'b1, XMIT[7-k]);
      bus.MOSI = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCK = 1'b1; bus.SSEL = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCK = 1'b0;
      repeat (8) @(negedge clk);
      model(q);
      check_writes("desel_win");

      // Reset after 3 bits with SSEL held low; later edges must be ignored.
      bus.SSEL = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < 3; k++) clk_bit(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_scroll = '0; last_exp = '0;
      for (int k = 0; k < 21; k++) clk_bit(1'b1, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      chk("rmb_miso", 32'(bus.MISO), 32'd0);
      check_writes("rmb");
      bus.SSEL = 1'b1;
      repeat (8) @(negedge clk);
      chk("rmb_miso_idle", 32'(bus.MISO), 32'(XMIT[7]));
      q = '{8'h06, 8'h01, 8'h02, 8'h5A};        txn(q, 0, "rmb_after");

      // Random transactions of varying length, some ending mid-byte.
      for (int r = 0; r < 10; r++) begin
         int n;
         n = $urandom_range(1, 7);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
         txn(q, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
